// File: rtl/securepuf_axi_pkg.sv
// securepuf_axi_pkg: shared burst/response types and FSM encodings for the securePUF AXI4 slave
package securepuf_axi_pkg;
  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_t;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  function automatic logic is_wrap_len_legal(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction
endpackage

// File: rtl/securepuf_axi_addr_gen.sv
// securepuf_axi_addr_gen: next beat address for FIXED/INCR/WRAP bursts
module securepuf_axi_addr_gen
  import securepuf_axi_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] nxt
);
  logic [ADDR_W-1:0] bytes, mask, incr;
  always_comb begin
    bytes = ADDR_W'(1) << size;
    mask = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1);
    incr = addr + bytes;
    nxt = (burst == FIXED) ? addr :
          (burst == WRAP && is_wrap_len_legal(len)) ? (addr & ~mask) | (incr & mask) : incr;
  end
endmodule

// File: rtl/securepuf_axi4_burst_mem.sv
// securepuf_axi4_burst_mem: AXI4 burst slave over an on-chip word memory with independent read/write FSMs
module securepuf_axi4_burst_mem
  import securepuf_axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int ID_W = 4,
  parameter int MEM_DEPTH = 64
) (
  input  logic                s00_axi_aclk,
  input  logic                s00_axi_areset,
  input  logic [ID_W-1:0]     s00_axi_awid,
  input  logic [ADDR_W-1:0]   s00_axi_awaddr,
  input  logic [7:0]          s00_axi_awlen,
  input  logic [2:0]          s00_axi_awsize,
  input  logic [1:0]          s00_axi_awburst,
  input  logic                s00_axi_awvalid,
  output logic                s00_axi_awready,
  input  logic [DATA_W-1:0]   s00_axi_wdata,
  input  logic [DATA_W/8-1:0] s00_axi_wstrb,
  input  logic                s00_axi_wlast,
  input  logic                s00_axi_wvalid,
  output logic                s00_axi_wready,
  output logic [ID_W-1:0]     s00_axi_bid,
  output logic [1:0]          s00_axi_bresp,
  output logic                s00_axi_bvalid,
  input  logic                s00_axi_bready,
  input  logic [ID_W-1:0]     s00_axi_arid,
  input  logic [ADDR_W-1:0]   s00_axi_araddr,
  input  logic [7:0]          s00_axi_arlen,
  input  logic [2:0]          s00_axi_arsize,
  input  logic [1:0]          s00_axi_arburst,
  input  logic                s00_axi_arvalid,
  output logic                s00_axi_arready,
  output logic [ID_W-1:0]     s00_axi_rid,
  output logic [DATA_W-1:0]   s00_axi_rdata,
  output logic [1:0]          s00_axi_rresp,
  output logic                s00_axi_rlast,
  output logic                s00_axi_rvalid,
  input  logic                s00_axi_rready
);
  localparam int BW = DATA_W / 8;
  localparam int LB = $clog2(BW);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_DEPTH * BW);
  logic clk, rst;
  assign clk = s00_axi_aclk;
  assign rst = s00_axi_areset;
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction
  function automatic logic beat_err(input logic [ADDR_W-1:0] a, input logic [2:0] s, input logic [7:0] l, input logic [1:0] b);
    return !in_range(a) || (s > 3'(LB)) || (b == WRAP && !is_wrap_len_legal(l));
  endfunction
  function automatic logic [IW-1:0] widx(input logic [ADDR_W-1:0] a);
    return a[LB+IW-1:LB];
  endfunction
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  w_state_t w_state, w_next;
  logic [ID_W-1:0] w_id;
  logic [ADDR_W-1:0] w_addr, w_nxt;
  logic [7:0] w_len;
  logic [2:0] w_size;
  logic [1:0] w_burst;
  logic [8:0] w_cnt;
  logic w_err, aw_hs, w_hs, w_over, w_we;
  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs = s00_axi_wvalid && s00_axi_wready;
  assign w_over = w_cnt > {1'b0, w_len};
  assign w_we = w_hs && !rst && !w_over && in_range(w_addr);
  securepuf_axi_addr_gen #(.ADDR_W(ADDR_W)) u_wag (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .nxt(w_nxt)
  );
  always_ff @(posedge clk) w_state <= rst ? W_IDLE : w_next;
  always_comb
    w_next = (w_state == W_IDLE) ? (aw_hs ? W_DATA : W_IDLE) :
             (w_state == W_DATA) ? ((w_hs && s00_axi_wlast) ? W_RESP : W_DATA) :
             (s00_axi_bready ? W_IDLE : W_RESP);
  always_comb begin
    s00_axi_awready = (w_state == W_IDLE) && !rst;
    s00_axi_wready = w_state == W_DATA;
    s00_axi_bvalid = w_state == W_RESP;
    s00_axi_bid = s00_axi_bvalid ? w_id : '0;
    s00_axi_bresp = (s00_axi_bvalid && w_err) ? SLVERR : OKAY;
  end
  // counter saturates at 256 so an overrun past len=255 is still seen as over
  always_ff @(posedge clk) begin
    if (rst) begin
      w_id <= '0;
      w_addr <= '0;
      w_len <= '0;
      w_size <= '0;
      w_burst <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_id <= s00_axi_awid;
      w_addr <= s00_axi_awaddr;
      w_len <= s00_axi_awlen;
      w_size <= s00_axi_awsize;
      w_burst <= s00_axi_awburst;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_nxt;
      w_cnt <= w_cnt + {8'd0, ~w_cnt[8]};
      w_err <= w_err || beat_err(w_addr, w_size, w_len, w_burst) || w_over ||
               (s00_axi_wlast && w_cnt < {1'b0, w_len});
    end
  end
  always_ff @(posedge clk)
    if (w_we)
      for (int i = 0; i < BW; i++)
        if (s00_axi_wstrb[i]) mem[widx(w_addr)][8*i +: 8] <= s00_axi_wdata[8*i +: 8];
  r_state_t r_state, r_next;
  logic [ID_W-1:0] r_id;
  logic [ADDR_W-1:0] r_addr, r_nxt, r_ld;
  logic [7:0] r_len, r_cnt, r_ll;
  logic [2:0] r_size, r_ls;
  logic [1:0] r_burst, r_lb;
  logic ar_hs, r_hs, r_load, r_lerr;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;
  assign r_hs = s00_axi_rvalid && s00_axi_rready;
  assign r_load = ar_hs || (r_hs && !s00_axi_rlast);
  securepuf_axi_addr_gen #(.ADDR_W(ADDR_W)) u_rag (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .nxt(r_nxt)
  );
  always_ff @(posedge clk) r_state <= rst ? R_IDLE : r_next;
  always_comb
    r_next = (r_state == R_IDLE) ? (ar_hs ? R_DATA : R_IDLE) :
             ((r_hs && s00_axi_rlast) ? R_IDLE : R_DATA);
  always_comb begin
    s00_axi_arready = (r_state == R_IDLE) && !rst;
    s00_axi_rvalid = r_state == R_DATA;
    s00_axi_rlast = s00_axi_rvalid && (r_cnt == r_len);
    s00_axi_rid = s00_axi_rvalid ? r_id : '0;
  end
  // the beat being loaded comes straight from AR on the first beat, else from the address generator
  always_comb begin
    r_ld = ar_hs ? s00_axi_araddr : r_nxt;
    r_ls = ar_hs ? s00_axi_arsize : r_size;
    r_ll = ar_hs ? s00_axi_arlen : r_len;
    r_lb = ar_hs ? s00_axi_arburst : r_burst;
    r_lerr = beat_err(r_ld, r_ls, r_ll, r_lb);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_cnt <= '0;
      s00_axi_rdata <= '0;
      s00_axi_rresp <= OKAY;
    end else begin
      if (ar_hs) begin
        r_id <= s00_axi_arid;
        r_addr <= s00_axi_araddr;
        r_len <= s00_axi_arlen;
        r_size <= s00_axi_arsize;
        r_burst <= s00_axi_arburst;
        r_cnt <= '0;
      end else if (r_load) begin
        r_addr <= r_nxt;
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_load) begin
        s00_axi_rdata <= in_range(r_ld) ? mem[widx(r_ld)] : '0;
        s00_axi_rresp <= r_lerr ? SLVERR : OKAY;
      end
    end
  end
endmodule

// File: tb/tb_securepuf_axi4_burst_mem.sv
// tb_securepuf_axi4_burst_mem: table, directed and random checks against a closed-form burst model
module tb_securepuf_axi4_burst_mem;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] awid = '0, arid = '0, bid, rid;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [7:0] awlen = '0, arlen = '0;
  logic [2:0] awsize = '0, arsize = '0;
  logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
  logic awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  int checks = 0, fails = 0;
  int lat_aw, lat_b, lat_r;
  logic [31:0] mm [64];
  logic [31:0] wd [64];
  logic [3:0] ws [64];
  logic [31:0] rd [64];
  logic [1:0] rr [64];
  logic rl [64];
  always #5 clk = ~clk;
  securepuf_axi4_burst_mem dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen), .s00_axi_awsize(awsize),
    .s00_axi_awburst(awburst), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen), .s00_axi_arsize(arsize),
    .s00_axi_arburst(arburst), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rid(rid), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rlast(rlast),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic to_fail(input string nm);
    checks++;
    fails++;
    $display("FAIL timeout waiting for %s", nm);
  endtask
  function automatic bit legal(input logic [7:0] l);
    return l inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction
  // byte address of beat k, straight from the burst rules
  function automatic int addr_of(input logic [11:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b, input int k);
    int by, span, base;
    by = 1 << s;
    span = (int'(l) + 1) * by;
    if (b == 2'd0) return int'(a);
    if (b == 2'd2 && legal(l)) begin
      base = int'(a) / span * span;
      return base + (int'(a) - base + k * by) % span;
    end
    return (int'(a) + k * by) % 4096;
  endfunction
  function automatic bit berr(input logic [11:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b, input int k);
    return s > 3'd2 || (b == 2'd2 && !legal(l)) || addr_of(a, l, s, b, k) >= 256;
  endfunction
  function automatic logic [1:0] wresp_m(input logic [11:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b, input int nb);
    bit e;
    e = nb != int'(l) + 1;
    for (int k = 0; k < nb && k <= int'(l); k++) e |= berr(a, l, s, b, k);
    return e ? 2'b10 : 2'b00;
  endfunction
  task automatic mwrite(input int ad, input logic [31:0] d, input logic [3:0] st);
    if (ad < 256)
      for (int j = 0; j < 4; j++) if (st[j]) mm[ad/4][8*j +: 8] = d[8*j +: 8];
  endtask
  task automatic do_write(input logic [3:0] id, input logic [11:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input int nb, output logic [1:0] resp, output logic [3:0] bid_o);
    int t;
    resp = 2'bxx;
    bid_o = 4'bxxxx;
    @(negedge clk);
    awid = id; awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
    t = 0;
    while (!awready) begin
      t++;
      if (t > 50) begin to_fail("awready"); awvalid = 1'b0; return; end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == nb - 1); wvalid = 1'b1;
      t = 0;
      while (!wready) begin
        t++;
        if (t > 50) begin to_fail("wready"); wvalid = 1'b0; return; end
        @(negedge clk);
      end
      if (i == 0) lat_aw = t;
      @(posedge clk);
      if (i <= int'(l)) mwrite(addr_of(a, l, s, b, i), wd[i], ws[i]);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid) begin
      t++;
      if (t > 50) begin to_fail("bvalid"); bready = 1'b0; return; end
      @(negedge clk);
    end
    lat_b = t; resp = bresp; bid_o = bid;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask
  // stab: check that rdata/rresp/rlast hold while the master stalls
  task automatic do_read(input logic [3:0] id, input logic [11:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [7:0] pat, input bit stab);
    int t, c, k;
    logic [31:0] pd;
    logic [1:0] pr;
    logic pl, stalled;
    @(negedge clk);
    arid = id; araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    t = 0;
    while (!arready) begin
      t++;
      if (t > 50) begin to_fail("arready"); arvalid = 1'b0; return; end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    k = 0; c = 0; t = 0; stalled = 1'b0; lat_r = 0;
    while (k <= int'(l)) begin
      rready = pat[c % 8];
      c++;
      if (!rvalid && k == 0) lat_r++;
      if (rvalid) begin
        if (stab && stalled) begin
          chk("stall_rdata", rdata, pd);
          chk("stall_rresp", rresp, pr);
          chk("stall_rlast", rlast, pl);
        end
        if (rready) begin
          rd[k] = rdata; rr[k] = rresp; rl[k] = rlast;
          chk("rid", rid, id);
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; pd = rdata; pr = rresp; pl = rlast;
        end
      end
      t++;
      if (t > 300) begin to_fail("rvalid"); rready = 1'b0; return; end
      @(negedge clk);
    end
    rready = 1'b0;
  endtask
  task automatic check_read(input string nm, input logic [11:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    int ad;
    for (int k = 0; k <= int'(l); k++) begin
      ad = addr_of(a, l, s, b, k);
      chk({nm, "_rdata"}, rd[k], ad < 256 ? mm[ad/4] : 32'h0);
      chk({nm, "_rresp"}, rr[k], berr(a, l, s, b, k) ? 2'b10 : 2'b00);
      chk({nm, "_rlast"}, rl[k], k == int'(l));
    end
  endtask
  typedef struct {
    logic [11:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  bresp;
    logic [1:0]  rresp0;
  } vec_t;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl [8];
    logic [1:0] resp, r2;
    logic [3:0] bo, b2;
    logic [11:0] a;
    logic [7:0] l;
    logic [2:0] s;
    logic [1:0] b;
    logic seen;
    tbl[0] = '{12'h040, 8'd0, 3'd2, 2'd1, 2'b00, 2'b00};
    tbl[1] = '{12'h044, 8'd1, 3'd3, 2'd1, 2'b10, 2'b10};
    tbl[2] = '{12'h050, 8'd2, 3'd2, 2'd2, 2'b10, 2'b10};
    tbl[3] = '{12'h058, 8'd1, 3'd2, 2'd2, 2'b00, 2'b00};
    tbl[4] = '{12'h100, 8'd0, 3'd2, 2'd1, 2'b10, 2'b10};
    tbl[5] = '{12'h0FC, 8'd0, 3'd2, 2'd1, 2'b00, 2'b00};
    tbl[6] = '{12'h063, 8'd0, 3'd2, 2'd0, 2'b00, 2'b00};
    tbl[7] = '{12'hFFC, 8'd1, 3'd2, 2'd1, 2'b10, 2'b10};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rlast", rlast, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_arready", arready, 1'b1);
    for (int i = 0; i < 64; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'h1, 12'h000, 8'd63, 3'd2, 2'd1, 64, resp, bo);
    chk("fill_bresp", resp, 2'b00);
    // INCR 8-beat write/read
    for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(4'h5, 12'h000, 8'd7, 3'd2, 2'd1, 8, resp, bo);
    chk("incr_bresp", resp, 2'b00);
    chk("incr_bid", bo, 4'h5);
    chk("aw_to_wready_lat", lat_aw, 0);
    chk("wlast_to_bvalid_lat", lat_b, 0);
    do_read(4'h9, 12'h000, 8'd7, 3'd2, 2'd1, 8'hFF, 1'b0);
    chk("ar_to_rvalid_lat", lat_r, 0);
    for (int k = 0; k < 8; k++) begin
      chk("incr_rdata", rd[k], 32'(k + 1));
      chk("incr_rresp", rr[k], 2'b00);
      chk("incr_rlast", rl[k], k == 7);
    end
    // WRAP write then INCR read-back in linear order
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    do_write(4'h2, 12'h018, 8'd3, 3'd2, 2'd2, 4, resp, bo);
    chk("wrap_bresp", resp, 2'b00);
    do_read(4'h3, 12'h010, 8'd3, 3'd2, 2'd1, 8'hFF, 1'b0);
    chk("wrap_w10", rd[0], 32'hC);
    chk("wrap_w14", rd[1], 32'hD);
    chk("wrap_w18", rd[2], 32'hA);
    chk("wrap_w1c", rd[3], 32'hB);
    // FIXED with a partial strobe on the last beat
    wd[0] = 32'h5; wd[1] = 32'h6; wd[2] = 32'h7; wd[3] = 32'h8;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF; ws[3] = 4'h5;
    do_write(4'h4, 12'h020, 8'd3, 3'd2, 2'd0, 4, resp, bo);
    chk("fixed_bresp", resp, 2'b00);
    do_read(4'h4, 12'h020, 8'd0, 3'd2, 2'd1, 8'hFF, 1'b0);
    chk("fixed_word", rd[0], 32'h0000_0008);
    // burst running off the end of memory
    wd[0] = 32'hDEAD_0001; wd[1] = 32'hDEAD_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(4'h6, 12'h0FC, 8'd1, 3'd2, 2'd1, 2, resp, bo);
    chk("edge_bresp", resp, 2'b10);
    do_read(4'h6, 12'h0FC, 8'd1, 3'd2, 2'd1, 8'hFF, 1'b0);
    chk("edge_rdata0", rd[0], 32'hDEAD_0001);
    chk("edge_rresp0", rr[0], 2'b00);
    chk("edge_rdata1", rd[1], 32'h0);
    chk("edge_rresp1", rr[1], 2'b10);
    // stalled read concurrent with a write elsewhere
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h1000 + 32'(i); ws[i] = 4'hF; end
    fork
      do_write(4'h7, 12'h0C0, 8'd3, 3'd2, 2'd1, 4, resp, bo);
      do_read(4'h8, 12'h000, 8'd3, 3'd2, 2'd1, 8'b1001_1001, 1'b1);
    join
    chk("conc_bresp", resp, 2'b00);
    for (int k = 0; k < 4; k++) chk("conc_rdata", rd[k], 32'(k + 1));
    do_read(4'h8, 12'h0C0, 8'd3, 3'd2, 2'd1, 8'hFF, 1'b0);
    check_read("conc_wb", 12'h0C0, 8'd3, 3'd2, 2'd1);
    // reset in the middle of a write burst
    @(negedge clk);
    awid = 4'h3; awaddr = 12'h080; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    chk("mid_awready", awready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'h5500 + 32'(i); wstrb = 4'hF; wvalid = 1'b1;
      chk("mid_wready", wready, 1'b1);
      @(posedge clk);
      mwrite(12'h080 + 4 * i, wdata, 4'hF);
      @(negedge clk);
    end
    wdata = 32'h5502; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    chk("mid_rst_awready", awready, 1'b0);
    rst = 1'b0; bready = 1'b1; seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= bvalid; end
    bready = 1'b0;
    chk("mid_no_bvalid", seen, 1'b0);
    chk("mid_awready_after", awready, 1'b1);
    // early wlast
    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'hA, 12'h0A0, 8'd3, 3'd2, 2'd1, 3, resp, bo);
    chk("early_wlast_bresp", resp, 2'b10);
    chk("early_wlast_bid", bo, 4'hA);
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i <= int'(tbl[v].len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write(4'(v), tbl[v].a, tbl[v].len, tbl[v].size, tbl[v].burst, int'(tbl[v].len) + 1, resp, bo);
      chk($sformatf("tbl%0d_bresp", v), resp, tbl[v].bresp);
      do_read(4'(v), tbl[v].a, tbl[v].len, tbl[v].size, tbl[v].burst, 8'hFF, 1'b0);
      chk($sformatf("tbl%0d_rresp0", v), rr[0], tbl[v].rresp0);
      check_read($sformatf("tbl%0d", v), tbl[v].a, tbl[v].len, tbl[v].size, tbl[v].burst);
    end
    repeat (25) begin
      a = 12'($urandom_range(0, 12'h13F));
      l = 8'($urandom_range(0, 7));
      s = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      b = 2'($urandom_range(0, 2));
      b2 = 4'($urandom);
      for (int i = 0; i <= int'(l); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      r2 = wresp_m(a, l, s, b, int'(l) + 1);
      do_write(b2, a, l, s, b, int'(l) + 1, resp, bo);
      chk("rnd_bresp", resp, r2);
      chk("rnd_bid", bo, b2);
      a = 12'($urandom_range(0, 12'h13F));
      l = 8'($urandom_range(0, 7));
      s = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      b = 2'($urandom_range(0, 2));
      do_read(4'($urandom), a, l, s, b, 8'($urandom) | 8'h01, 1'b1);
      check_read("rnd", a, l, s, b);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
